// File: rtl/ascii_pkg.sv
// Shared ASCII character constants, parser state and character-class types
// used by the hex parser, the command decoder and the hex display formatter.
package ascii_pkg;

    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_SP  = 8'h20;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_UA  = 8'h41;
    localparam logic [7:0] ASCII_UF  = 8'h46;
    localparam logic [7:0] ASCII_LA  = 8'h61;
    localparam logic [7:0] ASCII_LF_HEX = 8'h66;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DISCARD
    } parse_state_t;

    typedef enum logic [2:0] {
        CC_DIGIT,
        CC_TERM,
        CC_SPACE,
        CC_ESC,
        CC_INVALID
    } char_class_t;

endpackage

// File: rtl/ascii_hex_nibble.sv
// Combinational classifier: maps one ASCII code to its character class and,
// for hex digits, the 4-bit nibble value.
module ascii_hex_nibble
    import ascii_pkg::*;
(
    input  logic [7:0]  rx_data,
    output char_class_t char_class,
    output logic [3:0]  nibble
);

    always_comb begin
        char_class = CC_INVALID;
        nibble     = 4'h0;
        if (rx_data >= ASCII_0 && rx_data <= ASCII_9) begin
            char_class = CC_DIGIT;
            nibble     = rx_data[3:0];
        end else if ((rx_data >= ASCII_UA && rx_data <= ASCII_UF) ||
                     (rx_data >= ASCII_LA && rx_data <= ASCII_LF_HEX)) begin
            // Letters A-F / a-f have low nibbles 1..6, so +9 yields 10..15
            char_class = CC_DIGIT;
            nibble     = rx_data[3:0] + 4'd9;
        end else if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
            char_class = CC_TERM;
        end else if (rx_data == ASCII_SP) begin
            char_class = CC_SPACE;
        end else if (rx_data == ASCII_ESC) begin
            char_class = CC_ESC;
        end
    end

endmodule

// File: rtl/ascii_to_value.sv
// Accumulates a line of ASCII hex digits into a 32-bit value; pulses
// value_valid on a good entry and value_error on a malformed/over-long one.
module ascii_to_value
    import ascii_pkg::*;
#(
    parameter int MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] value_out,
    output logic        value_valid,
    output logic        value_error,
    output logic [3:0]  digit_count
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    char_class_t  w_class;
    logic [3:0]   w_nibble;

    parse_state_t r_state, w_state_next;
    logic [31:0]  r_acc, w_acc_next;
    logic [3:0]   r_count, w_count_next;
    logic [31:0]  r_value, w_value_next;
    logic         r_valid, w_valid_next;
    logic         r_error, w_error_next;

    ascii_hex_nibble u_nibble (
        .rx_data    (rx_data),
        .char_class (w_class),
        .nibble     (w_nibble)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_acc   <= 32'h0;
            r_count <= 4'h0;
            r_value <= 32'h0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_value <= w_value_next;
            r_valid <= w_valid_next;
            r_error <= w_error_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_value_next = r_value;
        w_valid_next = 1'b0;
        w_error_next = 1'b0;
        if (rx_valid) begin
            unique case (r_state)
                IDLE: begin
                    if (w_class == CC_DIGIT) begin
                        w_acc_next   = {28'h0, w_nibble};
                        w_count_next = 4'd1;
                        w_state_next = ACCUM;
                    end else if (w_class == CC_INVALID) begin
                        w_state_next = DISCARD;
                    end
                end
                ACCUM: begin
                    unique case (w_class)
                        CC_DIGIT: begin
                            // The digit limit keeps bits above 4*MAX_DIGITS at zero
                            if (r_count < MAX_CNT) begin
                                w_acc_next   = {r_acc[27:0], w_nibble};
                                w_count_next = r_count + 4'd1;
                            end else begin
                                w_state_next = DISCARD;
                            end
                        end
                        CC_TERM: begin
                            w_value_next = r_acc;
                            w_valid_next = 1'b1;
                            w_acc_next   = 32'h0;
                            w_count_next = 4'h0;
                            w_state_next = IDLE;
                        end
                        CC_ESC: begin
                            w_acc_next   = 32'h0;
                            w_count_next = 4'h0;
                            w_state_next = IDLE;
                        end
                        default: w_state_next = DISCARD;
                    endcase
                end
                DISCARD: begin
                    if (w_class == CC_TERM || w_class == CC_ESC) begin
                        w_error_next = (w_class == CC_TERM);
                        w_acc_next   = 32'h0;
                        w_count_next = 4'h0;
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign value_out   = r_value;
    assign value_valid = r_valid;
    assign value_error = r_error;
    assign digit_count = r_count;

endmodule

// File: doc/ascii_to_value.md
# ascii_to_value

Converts a stream of ASCII hex characters, typically from the UART receive path, into a 32-bit binary value. It is the inverse of the hex-to-ASCII display formatter. Command and parameter entry from the host terminal passes through this block. It accumulates up to `MAX_DIGITS` hex digits and, on a line terminator, emits the value with a one-cycle valid pulse. Malformed or over-long entries are flagged with a one-cycle error pulse.

## Interface
Parameters:
- `MAX_DIGITS`, default 8: maximum hex digits accepted per entry, legal range 1–8.

Ports:
- `clk`, input, 1: single system clock. All logic is on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `rx_data`, input, 8: received ASCII character.
- `rx_valid`, input, 1: `rx_data` is valid this cycle. Exactly one character is consumed per asserted cycle, with no backpressure.
- `value_out`, output, 32: last successfully parsed value, zero-extended.
- `value_valid`, output, 1: one-cycle pulse when `value_out` is updated.
- `value_error`, output, 1: one-cycle pulse when an entry is rejected.
- `digit_count`, output, 4: digits accumulated in the current entry, range 0..`MAX_DIGITS`.

## Operation
- Character classes:
  - DIGIT: '0'–'9' (0x30–0x39), 'A'–'F' (0x41–0x46), 'a'–'f' (0x61–0x66). Nibble value is 0–15.
  - TERM: CR 0x0D or LF 0x0A.
  - SPACE: 0x20.
  - ESC: 0x1B.
  - Any other code is INVALID.
- State machine `IDLE`, `ACCUM`, `DISCARD`. Transitions occur only on cycles with `rx_valid`=1. With `rx_valid`=0, state and accumulator hold.
- `IDLE`:
  - DIGIT: `acc` <= {28'h0, nibble}, `digit_count` <= 1, go to `ACCUM`.
  - SPACE, TERM, ESC: ignored, stay in `IDLE`. An empty line produces no pulse, which absorbs the LF of a CR-LF pair.
  - INVALID: go to `DISCARD`.
- `ACCUM`:
  - DIGIT with `digit_count` < `MAX_DIGITS`: `acc` <= {`acc`[27:0], nibble}, `digit_count`+1.
  - DIGIT with `digit_count` = `MAX_DIGITS` (overflow): go to `DISCARD`.
  - TERM: `value_out` <= `acc`, pulse `value_valid`, `digit_count` <= 0, go to `IDLE`.
  - ESC: clear `acc` and `digit_count`, go to `IDLE`, no pulse.
  - SPACE or INVALID: go to `DISCARD`.
- `DISCARD`:
  - TERM: pulse `value_error`, clear `acc` and `digit_count`, go to `IDLE`.
  - ESC: clear and go to `IDLE` with no pulse.
  - Any other character: stay in `DISCARD`.
- `value_out` is retained across errors and aborts. It changes only alongside `value_valid`.
- Upper bits of `acc` beyond 4×`MAX_DIGITS` are always zero.
- `value_valid` and `value_error` are never asserted in the same cycle.

## Timing
- Reset: when `reset_n`=0 at a rising edge, state returns to `IDLE` and `acc`, `value_out`, `digit_count`, `value_valid`, `value_error` are all cleared to 0. Reset takes priority over `rx_valid`. A reset mid-entry silently drops the partial entry with no pulse.
- Latency: `value_valid` or `value_error` is asserted in the cycle immediately after the edge that samples the TERM character. `value_out` is valid in that same cycle.
- Back-to-back `rx_valid` is supported every cycle. A DIGIT arriving in the cycle after TERM starts a new entry while the pulse of the previous entry is still high.
- All outputs are registered. No combinational path runs from `rx_data` to any output.

## Structure
- Shared package `ascii_pkg`:
  - Character constants `ASCII_CR`, `ASCII_LF`, `ASCII_SP`, `ASCII_ESC`.
  - State enum `parse_state_t` {`IDLE`, `ACCUM`, `DISCARD`}.
  - Character class enum `char_class_t`. The existing hex-to-ASCII formatter migrates its digit constants here.
- Sub-module `ascii_hex_nibble` is purely combinational. It takes `rx_data` and produces `char_class` and `nibble[3:0]`. Keeping it separate lets it be reused by the command decoder.

## Test plan
- "1A2b" CR → one `value_valid` pulse with `value_out`=32'h00001A2B. `digit_count` reads 4 before TERM and 0 after.
- "DEADBEEF" LF, then LF → `value_out`=32'hDEADBEEF with one pulse only. The second LF produces nothing.
- "123456789" CR with `MAX_DIGITS`=8 → `value_error` pulse. `value_out` keeps its previous value. The next "7" CR yields 32'h00000007.
- "12G4" CR → error pulse. "  5" CR (leading spaces) → `value_out`=32'h00000005. "5 6" CR → error pulse.
- "AB", then ESC, then "C" CR → no pulse for "AB", then `value_out`=32'h0000000C.
- "FF" with gaps of `rx_valid`=0, then `reset_n` low for one cycle, then CR → no pulse and all outputs 0. With `MAX_DIGITS`=4, "12345" CR → error pulse.
